// File: rtl/zuse_pkg.sv
// Shared definitions for the tinyZuse command path: opcode bytes, command
// encodings (which double as the control FSM state codes) and float field widths.
package zuse_pkg;

  localparam int EXP_W  = 7;
  localparam int MANT_W = 15;

  localparam logic [7:0] BYTE_SETR1    = 8'h82;
  localparam logic [7:0] BYTE_SETR2    = 8'h83;
  localparam logic [7:0] BYTE_READSTAT = 8'h84;
  localparam logic [7:0] BYTE_READR1   = 8'h85;
  localparam logic [7:0] BYTE_READR2   = 8'h86;
  localparam logic [7:0] BYTE_READRS   = 8'h87;
  localparam logic [7:0] BYTE_ADD      = 8'h88;
  localparam logic [7:0] BYTE_SUB      = 8'h89;
  localparam logic [7:0] BYTE_MUL      = 8'h8A;
  localparam logic [7:0] BYTE_DIV      = 8'h8B;
  localparam logic [7:0] BYTE_SQRT     = 8'h8C;

  typedef enum logic [3:0] {
    OP_NONE     = 4'd0,
    OP_SETR1    = 4'd1,
    OP_SETR2    = 4'd2,
    OP_READR1   = 4'd3,
    OP_READR2   = 4'd4,
    OP_READRS   = 4'd5,
    OP_ADD      = 4'd6,
    OP_SUB      = 4'd7,
    OP_READSTAT = 4'd9,
    OP_MUL      = 4'd10,
    OP_DIV      = 4'd11,
    OP_SQRT     = 4'd12
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPERAND = 2'd1,
    ST_HOLD    = 2'd2
  } parser_state_e;

  // OP_NONE marks a byte that is not a valid opcode.
  function automatic cmd_op_e decode_byte(input logic [7:0] b);
    case (b)
      BYTE_SETR1:    return OP_SETR1;
      BYTE_SETR2:    return OP_SETR2;
      BYTE_READSTAT: return OP_READSTAT;
      BYTE_READR1:   return OP_READR1;
      BYTE_READR2:   return OP_READR2;
      BYTE_READRS:   return OP_READRS;
      BYTE_ADD:      return OP_ADD;
      BYTE_SUB:      return OP_SUB;
      BYTE_MUL:      return OP_MUL;
      BYTE_DIV:      return OP_DIV;
      BYTE_SQRT:     return OP_SQRT;
      default:       return OP_NONE;
    endcase
  endfunction

  function automatic logic is_set_op(input cmd_op_e op);
    return (op == OP_SETR1) || (op == OP_SETR2);
  endfunction

endpackage

// File: rtl/zuse_cmd_parser.sv
// UART byte stream to tinyZuse command decoder with operand collection,
// valid/ready output and an inter-byte timeout that drops partial frames.
// state      | meaning
// ST_IDLE    | waiting for an opcode byte
// ST_OPERAND | collecting the three SETR1/SETR2 operand bytes
// ST_HOLD    | command presented, waiting for cmd_ready
module zuse_cmd_parser
  import zuse_pkg::*;
#(
  parameter int CLK_HZ     = 10000000,
  parameter int TIMEOUT_US = 10000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [3:0]        cmd_op,
  output logic              cmd_sign,
  output logic [EXP_W-1:0]  cmd_exp,
  output logic [MANT_W-1:0] cmd_mant,
  output logic              busy,
  output logic              err_opcode,
  output logic              err_timeout,
  output logic              err_overrun
);

  localparam int TIMEOUT_CYCLES = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int TIMER_W        = $clog2(TIMEOUT_CYCLES);

  parser_state_e      state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic               sign_q, sign_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [MANT_W-1:0]  mant_q, mant_d;
  logic               sh_sign_q, sh_sign_d;
  logic [EXP_W-1:0]   sh_exp_q, sh_exp_d;
  logic [7:0]         sh_mant_hi_q, sh_mant_hi_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               err_opcode_q, err_opcode_d;
  logic               err_timeout_q, err_timeout_d;
  logic               err_overrun_q, err_overrun_d;

  cmd_op_e dec_op;
  logic    take_opcode;

  assign dec_op      = decode_byte(rx_data);
  // A byte arriving with the handshake is decoded as if we were already idle.
  assign take_opcode = rx_valid && ((state_q == ST_IDLE) || (state_q == ST_HOLD && cmd_ready));

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    sign_d        = sign_q;
    exp_d         = exp_q;
    mant_d        = mant_q;
    sh_sign_d     = sh_sign_q;
    sh_exp_d      = sh_exp_q;
    sh_mant_hi_d  = sh_mant_hi_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;
    err_opcode_d  = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;

    case (state_q)
      ST_IDLE: ;
      ST_OPERAND: begin
        if (rx_valid) begin
          timer_d = '0;
          cnt_d   = cnt_q + 2'd1;
          case (cnt_q)
            2'd0: begin
              sh_sign_d = rx_data[7];
              sh_exp_d  = rx_data[6:0];
            end
            2'd1: sh_mant_hi_d = rx_data;
            default: begin
              // Payload only becomes visible once the frame is complete.
              sign_d  = sh_sign_q;
              exp_d   = sh_exp_q;
              mant_d  = {sh_mant_hi_q, rx_data[7:1]};
              state_d = ST_HOLD;
            end
          endcase
        end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_HOLD: begin
        if (cmd_ready) state_d = ST_IDLE;
        else if (rx_valid) err_overrun_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_opcode) begin
      if (dec_op == OP_NONE) begin
        err_opcode_d = 1'b1;
        state_d      = ST_IDLE;
      end else begin
        op_d = dec_op;
        if (is_set_op(dec_op)) begin
          cnt_d   = '0;
          timer_d = '0;
          state_d = ST_OPERAND;
        end else begin
          state_d = ST_HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      mant_q        <= '0;
      sh_sign_q     <= 1'b0;
      sh_exp_q      <= '0;
      sh_mant_hi_q  <= '0;
      cnt_q         <= '0;
      timer_q       <= '0;
      err_opcode_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      sign_q        <= sign_d;
      exp_q         <= exp_d;
      mant_q        <= mant_d;
      sh_sign_q     <= sh_sign_d;
      sh_exp_q      <= sh_exp_d;
      sh_mant_hi_q  <= sh_mant_hi_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      err_opcode_q  <= err_opcode_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign cmd_valid   = (state_q == ST_HOLD);
  assign busy        = (state_q != ST_IDLE);
  assign cmd_op      = op_q;
  assign cmd_sign    = sign_q;
  assign cmd_exp     = exp_q;
  assign cmd_mant    = mant_q;
  assign err_opcode  = err_opcode_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule
